// File: rtl/mul_sequencer_if.sv
// Handshake and shared-ALU bus of the shift-add multiply sequencer.
// The master side starts multiplies and provides the ALU; the slave side
// is the sequencer.
interface mul_sequencer_if #(
  parameter int DATAWIDTH = 32
);
  logic                 start_i;
  logic [DATAWIDTH-1:0] opA_i;
  logic [DATAWIDTH-1:0] opB_i;
  logic                 ready_o;
  logic                 busy_o;
  logic                 done_o;
  logic [DATAWIDTH-1:0] result_o;
  logic [DATAWIDTH-1:0] alu_srcA_o;
  logic [DATAWIDTH-1:0] alu_srcB_o;
  logic [3:0]           alu_ctrl_o;
  logic                 alu_req_o;
  logic [DATAWIDTH-1:0] alu_result_i;

  modport master (
    output start_i, opA_i, opB_i, alu_result_i,
    input  ready_o, busy_o, done_o, result_o,
           alu_srcA_o, alu_srcB_o, alu_ctrl_o, alu_req_o
  );

  modport slave (
    input  start_i, opA_i, opB_i, alu_result_i,
    output ready_o, busy_o, done_o, result_o,
           alu_srcA_o, alu_srcB_o, alu_ctrl_o, alu_req_o
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier that borrows an external adder (shared ALU).
// One multiplier bit is retired per RUN cycle; the low DATAWIDTH bits of
// opA*opB are registered on entry to DONE and held afterwards.
// Optional feature: define MUL_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (and to skip RUN when opB is zero).
module mul_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int CNT_WIDTH = 6
) (
  input logic            clk_i,
  input logic            rst_ni,
  mul_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATAWIDTH - 1);

  logic [1:0]           state;
  logic [DATAWIDTH-1:0] acc;
  logic [DATAWIDTH-1:0] mcand;
  logic [DATAWIDTH-1:0] mplier;
  logic [CNT_WIDTH-1:0] cnt;
  logic [DATAWIDTH-1:0] result;

  logic [DATAWIDTH-1:0] acc_next;
  logic [DATAWIDTH-1:0] mplier_next;
  logic                 run_last;

  // Next accumulator / multiplier values and the "this is the last RUN cycle" decision.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_next    = acc;
    mplier_next = mplier >> 1;
    run_last    = (cnt == LAST_CNT);
    if (mplier[0]) begin
      acc_next = bus.alu_result_i;
    end
`ifdef MUL_EARLY_EXIT_EN
    if (mplier_next == '0) begin
      run_last = 1'b1;
    end
`endif
  end

  // Sequencer state, datapath registers and the held result.
  // NOTE: reset is sampled on the clock edge here (synchronous), and all state uses <= so
  // every register sees the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            acc    <= '0;
            mcand  <= bus.opA_i;
            mplier <= bus.opB_i;
            cnt    <= '0;
`ifdef MUL_EARLY_EXIT_EN
            if (bus.opB_i == '0) begin
              state  <= S_DONE;
              result <= '0;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          cnt    <= cnt + CNT_WIDTH'(1);
          if (run_last) begin
            state  <= S_DONE;
            result <= acc_next;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Status and shared-ALU drive; start is ignored while RUN since ready is low there.
  assign bus.ready_o    = (state != S_RUN);
  assign bus.busy_o     = (state == S_RUN);
  assign bus.done_o     = (state == S_DONE);
  assign bus.result_o   = result;
  assign bus.alu_srcA_o = acc;
  assign bus.alu_srcB_o = mcand;
  assign bus.alu_ctrl_o = 4'b0000;
  assign bus.alu_req_o  = (state == S_RUN) && mplier[0];

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: a vector table of multiplies plus
// hand-written sequences for start-during-RUN, reset mid-RUN and
// back-to-back starts. The shared ALU is modelled as a plain adder.
module tb_mul_sequencer;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] exp_res;
    int            exp_reqs;
    int            exp_early_runs;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs [10];

  mul_sequencer_if #(.DATAWIDTH(DW)) bus ();

  mul_sequencer #(.DATAWIDTH(DW), .CNT_WIDTH(6)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  assign bus.alu_result_i = bus.alu_srcA_o + bus.alu_srcB_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int runs_for(input vec_t v);
`ifdef MUL_EARLY_EXIT_EN
    return v.exp_early_runs;
`else
    return DW;
`endif
  endfunction

  // Present a start at a negedge; it is taken at the following posedge.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.start_i = 1'b1;
    bus.opA_i   = a;
    bus.opB_i   = b;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  // Count RUN cycles and ALU requests until done_o, sampling at negedges.
  task automatic measure(output int runs, output int reqs, output bit timed_out);
    runs      = 0;
    reqs      = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.busy_o) runs++;
      if (bus.alu_req_o) reqs++;
    end
    check("done_timeout", 64'(timed_out), 64'd0);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done_o) pulses++;
    end
  endtask

  initial begin
    int runs;
    int reqs;
    int pulses;
    bit to;

    total = 0;
    bad   = 0;

    vecs[0] = '{32'd3,          32'd5,          32'd15,         2,  3};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32, 32};
    vecs[2] = '{32'd6,          32'd7,          32'd42,         3,  3};
    vecs[3] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1,  17};
    vecs[4] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  1,  1};
    vecs[5] = '{32'd0,          32'hAAAA_AAAA,  32'd0,          16, 32};
    vecs[6] = '{32'd100,        32'd250,        32'd25000,      6,  8};
    vecs[7] = '{32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  1,  1};
    vecs[8] = '{32'd5,          32'd0,          32'd0,          0,  0};
    vecs[9] = '{32'd7,          32'd4,          32'd28,         1,  3};

    // Reset with start held high: reset must win.
    rst_n       = 1'b0;
    bus.start_i = 1'b1;
    bus.opA_i   = 32'd11;
    bus.opB_i   = 32'd13;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  64'(bus.ready_o),    64'd1);
    check("rst_busy",   64'(bus.busy_o),     64'd0);
    check("rst_done",   64'(bus.done_o),     64'd0);
    check("rst_result", 64'(bus.result_o),   64'd0);
    check("rst_req",    64'(bus.alu_req_o),  64'd0);
    check("rst_srca",   64'(bus.alu_srcA_o), 64'd0);
    check("rst_srcb",   64'(bus.alu_srcB_o), 64'd0);
    check("alu_ctrl",   64'(bus.alu_ctrl_o), 64'd0);
    rst_n       = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);

    // Table-driven multiplies.
    foreach (vecs[i]) begin
      start_op(vecs[i].opa, vecs[i].opb);
      measure(runs, reqs, to);
      check($sformatf("v%0d_runs", i),   64'(runs), 64'(runs_for(vecs[i])));
      check($sformatf("v%0d_reqs", i),   64'(reqs), 64'(vecs[i].exp_reqs));
      check($sformatf("v%0d_result", i), 64'(bus.result_o), 64'(vecs[i].exp_res));
      check($sformatf("v%0d_ready", i),  64'(bus.ready_o), 64'd1);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i),  64'(bus.done_o), 64'd0);
      check($sformatf("v%0d_hold", i),   64'(bus.result_o), 64'(vecs[i].exp_res));
    end

    // Start pulsed during RUN must be ignored.
    start_op(32'd3, 32'd5);
    @(negedge clk);
    check("run1_busy",  64'(bus.busy_o),     64'd1);
    check("run1_ready", 64'(bus.ready_o),    64'd0);
    check("run1_srca",  64'(bus.alu_srcA_o), 64'd0);
    check("run1_srcb",  64'(bus.alu_srcB_o), 64'd3);
    check("run1_req",   64'(bus.alu_req_o),  64'd1);
    start_op(32'd9, 32'd9);
    measure(runs, reqs, to);
    check("ign_runs",   64'(runs + 1), 64'(runs_for(vecs[0])));
    check("ign_result", 64'(bus.result_o), 64'd15);
    count_done(40, pulses);
    check("ign_extra_done", 64'(pulses), 64'd0);
    check("ign_hold",   64'(bus.result_o), 64'd15);

    // Reset at RUN cycle 10 aborts the operation (start held to test dominance).
    start_op(32'd3, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    check("abort_busy_before", 64'(bus.busy_o), 64'd1);
    rst_n       = 1'b0;
    bus.start_i = 1'b1;
    @(negedge clk);
    check("abort_ready",  64'(bus.ready_o),    64'd1);
    check("abort_busy",   64'(bus.busy_o),     64'd0);
    check("abort_done",   64'(bus.done_o),     64'd0);
    check("abort_result", 64'(bus.result_o),   64'd0);
    check("abort_srca",   64'(bus.alu_srcA_o), 64'd0);
    check("abort_srcb",   64'(bus.alu_srcB_o), 64'd0);
    rst_n       = 1'b1;
    bus.start_i = 1'b0;
    count_done(40, pulses);
    check("abort_no_done", 64'(pulses), 64'd0);
    start_op(32'd6, 32'd7);
    measure(runs, reqs, to);
    check("post_abort_result", 64'(bus.result_o), 64'd42);
    @(negedge clk);

    // Back-to-back: new start presented in the DONE cycle.
    start_op(32'd3, 32'd5);
    measure(runs, reqs, to);
    check("b2b_first", 64'(bus.result_o), 64'd15);
    start_op(32'd2, 32'd8);
`ifdef MUL_EARLY_EXIT_EN
    check("b2b_busy", 64'(bus.busy_o), 64'd1);
    measure(runs, reqs, to);
    check("b2b_runs", 64'(runs), 64'd4);
`else
    check("b2b_busy", 64'(bus.busy_o), 64'd1);
    measure(runs, reqs, to);
    check("b2b_runs", 64'(runs), 64'(DW));
`endif
    check("b2b_result", 64'(bus.result_o), 64'd16);
    @(negedge clk);
    check("b2b_idle", 64'(bus.ready_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
